// File: rtl/dev_sel_bus_ctrl_pkg.sv
// Shared device map defaults, device index names and sequencer state encodings.
package dev_sel_bus_ctrl_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_NUM_DEV = 4;

  localparam logic [DEF_NUM_DEV*DEF_XLEN-1:0] DEF_DEV_BASE =
    {32'h1000_2000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_DEV*DEF_XLEN-1:0] DEF_DEV_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  localparam int DEV_BOOT = 0;
  localparam int DEV_SPI  = 1;
  localparam int DEV_UART = 2;
  localparam int DEV_GPIO = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dev_sel_bus_ctrl_if.sv
// Core request/response channel plus the per-device select/ack bundle.
interface dev_sel_bus_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_DEV = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [XLEN-1:0]         req_addr;
  logic                    req_we;
  logic [XLEN-1:0]         req_wdata;
  logic                    rsp_valid;
  logic [XLEN-1:0]         rsp_rdata;
  logic                    rsp_err;
  logic [NUM_DEV-1:0]      dev_sel;
  logic [XLEN-1:0]         dev_addr;
  logic                    dev_we;
  logic [XLEN-1:0]         dev_wdata;
  logic [NUM_DEV-1:0]      dev_ready;
  logic [NUM_DEV*XLEN-1:0] dev_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, dev_ready, dev_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dev_sel, dev_addr, dev_we, dev_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, dev_ready, dev_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dev_sel, dev_addr, dev_we, dev_wdata
  );
endinterface

// File: rtl/dev_sel_bus_ctrl_addr_decode.sv
// Combinational base/mask region match; lowest device index wins on overlap.
// Zero latency, no backpressure.
module dev_sel_bus_ctrl_addr_decode
  import dev_sel_bus_ctrl_pkg::*;
#(
  parameter int                       XLEN     = DEF_XLEN,
  parameter int                       NUM_DEV  = DEF_NUM_DEV,
  parameter logic [NUM_DEV*XLEN-1:0]  DEV_BASE = DEF_DEV_BASE,
  parameter logic [NUM_DEV*XLEN-1:0]  DEV_MASK = DEF_DEV_MASK,
  localparam int                      IDX_W    = idx_width(NUM_DEV)
) (
  input  logic [XLEN-1:0]    addr,
  output logic [NUM_DEV-1:0] hit,
  output logic               hit_any,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    idx     = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((addr & DEV_MASK[i*XLEN +: XLEN]) == DEV_BASE[i*XLEN +: XLEN]) begin
        hit     = '0;
        hit[i]  = 1'b1;
        hit_any = 1'b1;
        idx     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dev_sel_bus_ctrl.sv
// Device selector/sequencer: accept, select one device, wait for its ready (or timeout), respond.
// Min 3 cycles per hit access, 2 per decode miss; req_ready low outside IDLE so requests stall.
module dev_sel_bus_ctrl
  import dev_sel_bus_ctrl_pkg::*;
#(
  parameter int                       XLEN     = DEF_XLEN,
  parameter int                       NUM_DEV  = DEF_NUM_DEV,
  parameter logic [NUM_DEV*XLEN-1:0]  DEV_BASE = DEF_DEV_BASE,
  parameter logic [NUM_DEV*XLEN-1:0]  DEV_MASK = DEF_DEV_MASK,
  parameter int                       TIMEOUT  = 255
) (
  input logic               clk,
  input logic               rst,
  dev_sel_bus_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_DEV);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_DEV-1:0] hit;
  logic               hit_any;
  logic [IDX_W-1:0]   dec_idx;
  logic [XLEN-1:0]    off_mask;
  logic [XLEN-1:0]    sel_rdata;
  logic               sel_rdy;

  dev_sel_bus_ctrl_addr_decode #(
    .XLEN(XLEN), .NUM_DEV(NUM_DEV), .DEV_BASE(DEV_BASE), .DEV_MASK(DEV_MASK)
  ) u_dec (
    .addr(bus.req_addr), .hit(hit), .hit_any(hit_any), .idx(dec_idx)
  );

  // Region mask of the winning device; a miss keeps the raw address.
  always_comb begin
    off_mask = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (hit[i]) off_mask = DEV_MASK[i*XLEN +: XLEN];
    end
  end

  assign sel_rdata = bus.dev_rdata[int'(sel_idx)*XLEN +: XLEN];
  assign sel_rdy   = bus.dev_ready[sel_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sel_idx       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.dev_sel   <= '0;
      bus.dev_addr  <= '0;
      bus.dev_we    <= 1'b0;
      bus.dev_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.dev_addr  <= bus.req_addr & ~off_mask;
            bus.dev_we    <= bus.req_we;
            bus.dev_wdata <= bus.req_wdata;
            if (hit_any) begin
              bus.dev_sel <= hit;
              sel_idx     <= dec_idx;
              state       <= ST_ACCESS;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_rdy) begin
            bus.dev_sel   <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.dev_we ? '0 : sel_rdata;
            cnt           <= '0;
            state         <= ST_RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            bus.dev_sel   <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            cnt           <= '0;
            state         <= ST_RESP;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
          cnt           <= '0;
          state         <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dev_sel_bus_ctrl.sv
// Bench for dev_sel_bus_ctrl: vector table through a response scoreboard, plus stall and reset sequences.
module tb_dev_sel_bus_ctrl;
  import dev_sel_bus_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int NDEV = 4;
  localparam int TMO  = 8;
  // Device 3 overlaps the low 4K of the boot region so priority can be observed.
  localparam logic [NDEV*XLEN-1:0] TB_BASE =
    {32'h0000_0000, 32'h1000_1000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NDEV*XLEN-1:0] TB_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dev_sel_bus_ctrl_if #(.XLEN(XLEN), .NUM_DEV(NDEV)) bus ();

  dev_sel_bus_ctrl #(
    .XLEN(XLEN), .NUM_DEV(NDEV), .DEV_BASE(TB_BASE), .DEV_MASK(TB_MASK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          rdy_dev;
    int          rdy_delay;
    logic [3:0]  noise;
    logic [31:0] rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_selcyc;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs[9];
  rsp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string name);
    rsp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_err"}, 32'(bus.rsp_err), 32'(e.err));
      chk({name, "_rdata"}, bus.rsp_rdata, e.rdata);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    int selcyc;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_we    = v.we;
    bus.req_wdata = v.wdata;
    sb_q.push_back('{v.exp_err, v.exp_rdata});
    step();
    bus.req_valid = 1'b0;
    chk({name, "_req_ready_busy"}, 32'(bus.req_ready), 32'h0);
    chk({name, "_dev_sel"}, 32'(bus.dev_sel), 32'(v.exp_sel));
    if (v.exp_sel != 4'b0) begin
      chk({name, "_dev_addr"}, bus.dev_addr, v.exp_addr);
      chk({name, "_dev_we"}, 32'(bus.dev_we), 32'(v.we));
      chk({name, "_dev_wdata"}, bus.dev_wdata, v.wdata);
    end
    for (int i = 0; i < NDEV; i++) bus.dev_rdata[i*XLEN +: XLEN] = 32'hEE00_0000 | 32'(i);
    if (v.rdy_dev >= 0) bus.dev_rdata[v.rdy_dev*XLEN +: XLEN] = v.rdata;
    lat = 1;
    selcyc = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.dev_sel == v.exp_sel) selcyc++;
      if (v.rdy_dev >= 0 && (lat - 1) == v.rdy_delay) bus.dev_ready = 4'(1 << v.rdy_dev);
      else bus.dev_ready = v.noise;
      step();
      lat++;
    end
    bus.dev_ready = '0;
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no rsp_valid expected one within 40 cycles", name);
      void'(sb_q.pop_front());
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
      if (v.exp_sel != 4'b0) chk({name, "_sel_cycles"}, 32'(selcyc), 32'(v.exp_selcyc));
      chk({name, "_sel_cleared"}, 32'(bus.dev_sel), 32'h0);
      sb_check(name);
    end
    step();
    chk({name, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'h0);
    chk({name, "_rsp_err_drop"}, 32'(bus.rsp_err), 32'h0);
    chk({name, "_rsp_rdata_drop"}, bus.rsp_rdata, 32'h0);
    chk({name, "_req_ready_back"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    int sent;
    int rsps;
    logic acc;

    //        addr           we    wdata          rdy_dev   dly noise    rdata          exp_sel             exp_addr      err   exp_rdata      lat selcyc
    vecs[0] = '{32'h1000_1004, 1'b0, 32'h0,         DEV_UART, 0, 4'b0000, 32'h0000_00A5, 4'(1 << DEV_UART), 32'h0000_0004, 1'b0, 32'h0000_00A5, 2, 1};
    vecs[1] = '{32'h2000_0000, 1'b0, 32'h0,         -1,       0, 4'b0000, 32'h0,         4'b0000,           32'h0,         1'b1, 32'h0,         1, 0};
    vecs[2] = '{32'h1000_0010, 1'b1, 32'hDEAD_BEEF, -1,       0, 4'b0000, 32'h0,         4'(1 << DEV_SPI),  32'h0000_0010, 1'b1, 32'h0,         9, 8};
    vecs[3] = '{32'h1000_0ABC, 1'b0, 32'h0,         DEV_SPI,  7, 4'b0000, 32'h1234_5678, 4'(1 << DEV_SPI),  32'h0000_0ABC, 1'b0, 32'h1234_5678, 9, 8};
    vecs[4] = '{32'h0000_0040, 1'b0, 32'h0,         DEV_BOOT, 3, 4'b1000, 32'h0000_B007, 4'(1 << DEV_BOOT), 32'h0000_0040, 1'b0, 32'h0000_B007, 5, 4};
    vecs[5] = '{32'h1000_1FFC, 1'b1, 32'h0000_CAFE, DEV_UART, 1, 4'b0000, 32'h5555_AAAA, 4'(1 << DEV_UART), 32'h0000_0FFC, 1'b0, 32'h0,         3, 2};
    vecs[6] = '{32'h1000_1008, 1'b0, 32'h0,         -1,       0, 4'b0011, 32'h0,         4'(1 << DEV_UART), 32'h0000_0008, 1'b1, 32'h0,         9, 8};
    vecs[7] = '{32'h0000_8000, 1'b0, 32'h0,         DEV_BOOT, 2, 4'b0000, 32'h0BAD_F00D, 4'(1 << DEV_BOOT), 32'h0000_8000, 1'b0, 32'h0BAD_F00D, 4, 3};
    vecs[8] = '{32'h1000_3000, 1'b1, 32'h1111_2222, -1,       0, 4'b0000, 32'h0,         4'b0000,           32'h0,         1'b1, 32'h0,         1, 0};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.dev_ready = '0;
    bus.dev_rdata = '0;

    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_dev_sel", 32'(bus.dev_sel), 32'h0);
    chk("rst_dev_addr", bus.dev_addr, 32'h0);
    chk("rst_dev_we", 32'(bus.dev_we), 32'h0);
    chk("rst_dev_wdata", bus.dev_wdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Request held valid through a busy window must be accepted later, not dropped.
    sent = 0;
    rsps = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (sent < 2);
      bus.req_addr  = 32'h3000_0000 + 32'(sent * 4);
      bus.req_we    = 1'b0;
      acc = bus.req_valid && bus.req_ready;
      if (acc) sb_q.push_back('{1'b1, 32'h0});
      step();
      if (acc) sent++;
      if (bus.rsp_valid) begin
        rsps++;
        chk("b2b_req_ready_in_resp", 32'(bus.req_ready), 32'h0);
        sb_check("b2b");
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepted", 32'(sent), 32'd2);
    chk("b2b_responses", 32'(rsps), 32'd2);

    // Reset in the middle of an access aborts it immediately.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_1010;
    bus.req_we    = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("midrst_sel_before", 32'(bus.dev_sel), 32'(4'(1 << DEV_UART)));
    rst = 1'b1;
    #1;
    chk("midrst_dev_sel", 32'(bus.dev_sel), 32'h0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    rst = 1'b0;
    step();
    run_vec(vecs[0], "post_rst_read");
    run_vec(vecs[2], "post_rst_timeout");

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
